// File: rtl/vector_lsu.sv
// ============================================================================
// Module  : vector_lsu
// Purpose : Vector load/store sequencer; splits a vector access into
//           unit-stride 32-bit memory transactions, one outstanding at a time.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module vector_lsu #(
  parameter int VLEN_WORDS = 4,
  parameter int ADDR_W     = 32
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      start_i,
  input  logic                      is_load_i,
  input  logic                      is_store_i,
  input  logic [ADDR_W-1:0]         base_addr_i,
  input  logic [32*VLEN_WORDS-1:0]  vs_data_i,
  output logic                      busy_o,
  output logic                      done_o,
  output logic                      err_o,
  output logic                      data_req_o,
  output logic [ADDR_W-1:0]         data_addr_o,
  output logic                      data_wr_o,
  output logic [31:0]               data_wdata_o,
  input  logic                      data_gnt_i,
  input  logic                      data_rvalid_i,
  input  logic [31:0]               data_rdata_i,
  output logic                      vrf_wr_en_o,
  output logic [32*VLEN_WORDS-1:0]  vrf_wr_data_o
);

  localparam int                 IDX_W    = $clog2(VLEN_WORDS);
  localparam logic [IDX_W-1:0]   LAST_IDX = IDX_W'(VLEN_WORDS - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t                         r_state;
  state_t                         w_state_next;
  logic [IDX_W-1:0]               r_idx;
  logic                           r_is_store;
  logic [ADDR_W-1:0]              r_base;
  logic [VLEN_WORDS-1:0][31:0]    r_vs_data;
  logic [VLEN_WORDS-1:0][31:0]    r_buf;
  logic [VLEN_WORDS-1:0][31:0]    r_vrf_data;
  logic [VLEN_WORDS-1:0][31:0]    w_buf_next;
  logic                           r_err;
  logic                           w_legal;
  logic                           w_last;

  assign w_legal       = (is_load_i ^ is_store_i) && (base_addr_i[1:0] == 2'b00);
  assign w_last        = (r_idx == LAST_IDX);
  assign err_o         = r_err;
  assign vrf_wr_data_o = r_vrf_data;

  always_ff @(posedge clk) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_state_next;
  end

  always_comb begin
    w_state_next        = r_state;
    busy_o              = 1'b0;
    done_o              = 1'b0;
    data_req_o          = 1'b0;
    data_addr_o         = '0;
    data_wr_o           = 1'b0;
    data_wdata_o        = '0;
    vrf_wr_en_o         = 1'b0;
    w_buf_next          = r_buf;
    w_buf_next[r_idx]   = data_rdata_i;
    case (r_state)
      IDLE: begin
        if (start_i && w_legal) w_state_next = REQ;
      end
      REQ: begin
        busy_o       = 1'b1;
        data_req_o   = 1'b1;
        // Address arithmetic wraps silently at 2^ADDR_W.
        data_addr_o  = r_base + (ADDR_W'(r_idx) << 2);
        data_wr_o    = r_is_store;
        data_wdata_o = r_vs_data[r_idx];
        if (data_gnt_i) begin
          if (!r_is_store)  w_state_next = WAIT;
          else if (w_last)  w_state_next = DONE;
        end
      end
      WAIT: begin
        busy_o = 1'b1;
        if (data_rvalid_i) w_state_next = w_last ? DONE : REQ;
      end
      DONE: begin
        busy_o       = 1'b1;
        done_o       = 1'b1;
        vrf_wr_en_o  = !r_is_store;
        w_state_next = IDLE;
      end
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_idx      <= '0;
      r_is_store <= 1'b0;
      r_base     <= '0;
      r_vs_data  <= '0;
      r_buf      <= '0;
      r_vrf_data <= '0;
      r_err      <= 1'b0;
    end else begin
      r_err <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start_i) begin
            r_is_store <= is_store_i;
            r_base     <= base_addr_i;
            r_vs_data  <= vs_data_i;
            r_idx      <= '0;
            r_err      <= !w_legal;
          end
        end
        REQ: begin
          if (data_gnt_i && r_is_store && !w_last) r_idx <= r_idx + 1'b1;
        end
        WAIT: begin
          if (data_rvalid_i) begin
            r_buf <= w_buf_next;
            // Publish the vector only once the final element has landed.
            if (w_last) r_vrf_data <= w_buf_next;
            else        r_idx      <= r_idx + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: doc/vector_lsu.md
Name: vector_lsu

Overview:
- Vector load/store sequencer directly downstream of decode/control.
- Consumes the is_vector_load/is_vector_store indications, the rs1 base address and the vector store operand.
- Breaks each vector access into VLEN_WORDS unit-stride 32-bit data-memory transactions, one outstanding at a time.
- Stalls the core while busy; on completion returns the assembled vector to the vector register file write port.

Parameters:
- VLEN_WORDS, 4, number of 32-bit elements per vector register (power of two, 2..16).
- ADDR_W, 32, data address width.

Ports:
- clk  in  1  core clock.
- reset  in  1  synchronous, active-high reset.
- start_i  in  1  one-cycle launch pulse from control (is_vector_load_o | is_vector_store_o qualified).
- is_load_i  in  1  vector load request.
- is_store_i  in  1  vector store request.
- base_addr_i  in  ADDR_W  rs1 base address.
- vs_data_i  in  32*VLEN_WORDS  store operand from VRF; element k = bits [32k+31:32k].
- busy_o  out  1  sequencer active; core stalls fetch/decode.
- done_o  out  1  one-cycle completion pulse.
- err_o  out  1  one-cycle illegal/misaligned pulse.
- data_req_o  out  1  memory request valid.
- data_addr_o  out  ADDR_W  request address.
- data_wr_o  out  1  1 = write, 0 = read.
- data_wdata_o  out  32  write data.
- data_gnt_i  in  1  memory accepted the current request.
- data_rvalid_i  in  1  read data valid.
- data_rdata_i  in  32  read data.
- vrf_wr_en_o  out  1  vector register write strobe (loads only).
- vrf_wr_data_o  out  32*VLEN_WORDS  assembled load vector.

Behaviour:
- All state is registered on the rising edge of clk. Reset is synchronous and active-high.
- Reset values: all outputs 0, state IDLE, element index 0, load buffer cleared.
- FSM states: IDLE, REQ, WAIT, DONE.
- IDLE:
  - busy_o=0.
  - On start_i, capture is_load_i, is_store_i, base_addr_i and vs_data_i.
  - Legal launch = exactly one of is_load_i/is_store_i set AND base_addr_i[1:0]==0. A legal launch goes to REQ with index=0.
  - Illegal launch pulses err_o for one cycle the next cycle, issues no memory traffic and stays in IDLE.
- REQ:
  - data_req_o=1, data_addr_o = base + 4*index (modulo 2^ADDR_W, wraps silently).
  - data_wr_o = store flag; data_wdata_o = captured element[index].
  - Request and address are held stable until data_gnt_i.
  - On gnt for a store: if index==VLEN_WORDS-1 go to DONE, else increment index and stay in REQ. Back-to-back grants give one element per cycle.
  - On gnt for a load: go to WAIT with data_req_o=0.
- WAIT:
  - On data_rvalid_i, write data_rdata_i into buffer element[index].
  - Then go to DONE if last element, else increment index and return to REQ.
  - rvalid arriving in the same cycle as the gnt is not supported; the earliest rvalid is the cycle after gnt.
- DONE (one cycle):
  - done_o=1.
  - For loads: vrf_wr_en_o=1 and vrf_wr_data_o = buffer.
  - Then IDLE.
- vrf_wr_data_o holds its last value when vrf_wr_en_o=0.
- busy_o=1 in REQ, WAIT and DONE; it asserts the cycle after a legal start_i.
- start_i while busy_o=1 is ignored; the captured operands are unaffected.
- Minimum latency from start_i to done_o, zero-wait memory:
  - store: VLEN_WORDS+1 cycles.
  - load: 2*VLEN_WORDS+1 cycles.
- Stray data_rvalid_i outside WAIT is ignored. data_gnt_i while data_req_o=0 is ignored.
- Reset mid-operation: return to IDLE immediately, drop the in-flight request, no done_o, no vrf_wr_en_o. A late rvalid after reset is ignored.

Test Plan:
- Store: base=0x100, vs_data={0xDDDD,0xCCCC,0xBBBB,0xAAAA}, gnt tied 1 -> writes 0xAAAA@0x100, 0xBBBB@0x104, 0xCCCC@0x108, 0xDDDD@0x10C on consecutive cycles; done_o 5 cycles after start_i; vrf_wr_en_o stays 0.
- Load: base=0x200, rvalid one cycle after each gnt with rdata=0x11,0x22,0x33,0x44 -> one vrf_wr_en_o pulse with vrf_wr_data_o=0x00000044_00000033_00000022_00000011; done_o at cycle 9.
- Backpressure: gnt withheld 3 cycles on element 1 -> data_req_o, data_addr_o=0x204 and data_wdata_o stay stable until gnt; no element is skipped or duplicated.
- Misaligned base 0x102, and separately start with both is_load_i and is_store_i set -> err_o single pulse, no data_req_o, busy_o stays 0.
- Reset asserted during WAIT of element 2, then a late rvalid -> state returns to IDLE, no done_o, no vrf_wr_en_o; a new load from 0x300 then completes correctly.
- start_i pulsed again mid-store, and address wrap with base=0xFFFFFFF8 -> second start ignored; wrap addresses are 0xFFFFFFF8, 0xFFFFFFFC, 0x0, 0x4.
